// File: rtl/mul2x2_pkg.sv
// Shared types and constants for the 2x2 multiplier accumulator.
// Imported by the product stage and the accumulator top.
package mul2x2_pkg;

  localparam int PROD_W = 4;
  localparam int OPER_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/mul2x2_prod.sv
// Gate-level 2x2 unsigned multiplier: {a,b} * {c,d}.
// Matches the upstream half-adder array bit for bit.
module mul2x2_prod
  import mul2x2_pkg::*;
(
  input  logic              a,
  input  logic              b,
  input  logic              c,
  input  logic              d,
  output logic [PROD_W-1:0] prod
);

  logic ad, bc, ac, bd;

  assign ad = a & d;
  assign bc = b & c;
  assign ac = a & c;
  assign bd = b & d;

  // Two half adders: column 1 then carry into column 2.
  assign prod[0] = bd;
  assign prod[1] = ad ^ bc;
  assign prod[2] = ac ^ (ad & bc);
  assign prod[3] = ac & ad & bc;

endmodule

// File: rtl/mul2x2_accumulator.sv
// Sums N_TERMS 2x2 products into a saturating accumulator and
// presents the result on a held valid/ready output.
module mul2x2_accumulator
  import mul2x2_pkg::*;
#(
  parameter int N_TERMS = 8,
  parameter int ACC_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             d,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             busy,
  output logic [ACC_W-1:0] sum,
  output logic             sum_valid,
  input  logic             sum_ready,
  output logic             overflow
);

  localparam int CNT_W = $clog2(N_TERMS + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_TERMS - 1);

  state_t state, state_nx;

  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  acc_nx;
  logic [ACC_W:0]    ext;
  logic [CNT_W-1:0]  count;
  logic [PROD_W-1:0] prod;
  logic              sat;
  logic              xfer;
  logic              last;

  mul2x2_prod u_prod (
    .a    (a),
    .b    (b),
    .c    (c),
    .d    (d),
    .prod (prod)
  );

  // One extra bit catches the carry that signals saturation.
  assign ext    = {1'b0, acc} + (ACC_W + 1)'(prod);
  assign sat    = ext[ACC_W];
  assign acc_nx = sat ? '1 : ext[ACC_W-1:0];
  assign xfer   = (state == ST_ACCUM) && in_valid;
  assign last   = (count == LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    sum_valid = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) state_nx = ST_ACCUM;
      end
      ST_ACCUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (xfer && last) state_nx = ST_DONE;
      end
      ST_DONE: begin
        busy      = 1'b1;
        sum_valid = 1'b1;
        if (sum_ready) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      count    <= '0;
      sum      <= '0;
      overflow <= 1'b0;
    end else if (state == ST_IDLE && start) begin
      acc      <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (xfer) begin
      acc   <= acc_nx;
      count <= count + 1'b1;
      if (sat)  overflow <= 1'b1;
      if (last) sum      <= acc_nx;
    end
  end

endmodule

// File: tb/tb_mul2x2_accumulator.sv
// Directed plus randomized bench; a plain-arithmetic model
// (min of the true total and the width maximum) gives expectations.
module tb_mul2x2_accumulator;

  logic clk = 1'b0;
  logic rst;
  logic a, b, c, d;
  logic in_valid;
  logic sum_ready;
  logic start0, start1, start2;

  logic       in_ready0, busy0, sum_valid0, overflow0;
  logic [7:0] sum0;
  logic       in_ready1, busy1, sum_valid1, overflow1;
  logic [5:0] sum1;
  logic       in_ready2, busy2, sum_valid2, overflow2;
  logic [7:0] sum2;

  int checks   = 0;
  int failures = 0;
  int pa[8];
  int pb[8];
  int total;
  logic [7:0] held;

  always #5 clk = ~clk;

  mul2x2_accumulator #(.N_TERMS(8), .ACC_W(8)) dut0 (
    .clk(clk), .rst(rst), .start(start0),
    .a(a), .b(b), .c(c), .d(d),
    .in_valid(in_valid), .in_ready(in_ready0), .busy(busy0),
    .sum(sum0), .sum_valid(sum_valid0), .sum_ready(sum_ready),
    .overflow(overflow0)
  );

  mul2x2_accumulator #(.N_TERMS(8), .ACC_W(6)) dut1 (
    .clk(clk), .rst(rst), .start(start1),
    .a(a), .b(b), .c(c), .d(d),
    .in_valid(in_valid), .in_ready(in_ready1), .busy(busy1),
    .sum(sum1), .sum_valid(sum_valid1), .sum_ready(sum_ready),
    .overflow(overflow1)
  );

  mul2x2_accumulator #(.N_TERMS(1), .ACC_W(8)) dut2 (
    .clk(clk), .rst(rst), .start(start2),
    .a(a), .b(b), .c(c), .d(d),
    .in_valid(in_valid), .in_ready(in_ready2), .busy(busy2),
    .sum(sum2), .sum_valid(sum_valid2), .sum_ready(sum_ready),
    .overflow(overflow2)
  );

  function automatic int sat_sum(input int t, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (t > mx) ? mx : t;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int x, input int y);
    a = x[1];
    b = x[0];
    c = y[1];
    d = y[0];
  endtask

  // Feeds pa/pb; the transfer edge of the last pair lands in DONE.
  task automatic feed(input bit gaps);
    total = 0;
    for (int i = 0; i < 8; i++) begin
      if (gaps) begin
        in_valid = 1'b0;
        set_ops(int'($urandom_range(3)), int'($urandom_range(3)));
        repeat ($urandom_range(2)) tick();
      end
      set_ops(pa[i], pb[i]);
      in_valid = 1'b1;
      total += pa[i] * pb[i];
      tick();
      in_valid = 1'b0;
      if (i < 7) chk("early_valid", int'(sum_valid0), 0);
    end
  endtask

  task automatic start_both();
    start0 = 1'b1;
    start1 = 1'b1;
    tick();
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic finish_both();
    sum_ready = 1'b1;
    tick();
    sum_ready = 1'b0;
    chk("idle_busy0", int'(busy0), 0);
    chk("idle_valid1", int'(sum_valid1), 0);
  endtask

  initial begin
    rst = 1'b1;
    {a, b, c, d} = 4'b0;
    in_valid  = 1'b0;
    sum_ready = 1'b0;
    start0 = 1'b0;
    start1 = 1'b0;
    start2 = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_sum", int'(sum0), 0);
    chk("rst_valid", int'(sum_valid0), 0);
    chk("rst_ready", int'(in_ready0), 0);
    chk("rst_busy", int'(busy0), 0);
    chk("rst_ovf", int'(overflow0), 0);

    // Basic run and saturation: 8 x (3*3).
    for (int i = 0; i < 8; i++) begin pa[i] = 3; pb[i] = 3; end
    start_both();
    chk("accum_ready", int'(in_ready0), 1);
    chk("accum_busy", int'(busy1), 1);
    feed(1'b0);
    chk("basic_valid", int'(sum_valid0), 1);
    chk("basic_sum", int'(sum0), 72);
    chk("basic_ovf", int'(overflow0), 0);
    chk("sat_sum", int'(sum1), sat_sum(total, 6));
    chk("sat_ovf", int'(overflow1), 1);
    chk("done_ready", int'(in_ready0), 0);

    // Output hold with ignored start pulses.
    held = sum0;
    for (int i = 0; i < 5; i++) begin
      start0 = i[0];
      tick();
      chk("hold_valid", int'(sum_valid0), 1);
      chk("hold_sum", int'(sum0), int'(held));
    end
    start0 = 1'b1;
    finish_both();
    start0 = 1'b0;
    tick();
    chk("start_on_ack_ignored", int'(busy0), 0);
    chk("idle_ready", int'(in_ready0), 0);
    chk("ovf_sticky", int'(overflow1), 1);
    chk("idle_sum_held", int'(sum1), 63);
    start_both();
    chk("ovf_cleared", int'(overflow1), 0);

    // Gapped run with products 0,1,2,3,4,6,9,0.
    pa = '{0, 1, 2, 3, 2, 3, 3, 0};
    pb = '{0, 1, 1, 1, 2, 2, 3, 3};
    feed(1'b1);
    chk("gap_valid", int'(sum_valid0), 1);
    chk("gap_sum", int'(sum0), 25);
    chk("gap_sum_w6", int'(sum1), sat_sum(total, 6));
    finish_both();

    // Randomized runs against the model.
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 8; i++) begin
        pa[i] = int'($urandom_range(3));
        pb[i] = int'($urandom_range(3));
      end
      start_both();
      feed(r[0]);
      chk("rnd_sum8", int'(sum0), sat_sum(total, 8));
      chk("rnd_sum6", int'(sum1), sat_sum(total, 6));
      chk("rnd_ovf6", int'(overflow1), int'(total > 63));
      finish_both();
    end

    // Reset mid-run after three transfers.
    start_both();
    in_valid = 1'b1;
    set_ops(3, 3);
    repeat (3) tick();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_busy", int'(busy0), 0);
    chk("mid_rst_ready", int'(in_ready1), 0);
    chk("mid_rst_sum", int'(sum0), 0);
    chk("mid_rst_ovf", int'(overflow1), 0);
    chk("mid_rst_valid", int'(sum_valid0), 0);
    for (int i = 0; i < 8; i++) begin pa[i] = 2; pb[i] = 1; end
    start_both();
    feed(1'b0);
    chk("post_rst_sum", int'(sum0), 16);
    finish_both();

    // Exhaustive product through the single-term instance.
    for (int x = 0; x < 4; x++) begin
      for (int y = 0; y < 4; y++) begin
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        set_ops(x, y);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("prod_valid", int'(sum_valid2), 1);
        chk($sformatf("prod_%0dx%0d", x, y), int'(sum2), x * y);
        sum_ready = 1'b1;
        tick();
        sum_ready = 1'b0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
